booth_seq_mult: RTL and testbench

//  Iterative radix-2 Booth multiplier, parametrised in operand width, with a signed/unsigned mode per request.

---
 rtl/booth_pkg.sv | 18 +
 rtl/booth_seq_mult_if.sv | 25 ++
 rtl/booth_step.sv | 26 ++
 rtl/booth_seq_mult.sv | 101 ++++++++++
 tb/tb_booth_seq_mult.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Operand/result handshake bundle for booth_seq_mult.
interface booth_seq_mult_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_x;
  logic [WIDTH-1:0]   in_y;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic               out_neg;
  logic               busy;

  modport master (
    output in_valid, in_signed, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_p, out_neg, busy
  );

  modport slave (
    input  in_valid, in_signed, in_x, in_y, out_ready,
    output in_ready, out_valid, out_p, out_neg, busy
  );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub the multiplicand, then arithmetic
// right shift of {A,Q,q_1}.
module booth_step #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] m,
  input  logic [W-1:0] q,
  input  logic         q_1,
  output logic [W-1:0] a_nxt,
  output logic [W-1:0] q_nxt,
  output logic         q_1_nxt
);
  logic [W-1:0] sum;

  always_comb begin
    unique case ({q[0], q_1})
      2'b10:   sum = a - m;
      2'b01:   sum = a + m;
      default: sum = a;
    endcase
    a_nxt   = {sum[W-1], sum[W-1:1]};
    q_nxt   = {sum[0], q[W-1:1]};
    q_1_nxt = q[0];
  end
endmodule

// File: rtl/booth_seq_mult.sv
// Iterative radix-2 Booth multiplier, one multiplier bit per clock, with
// valid/ready on operands and result and optional magnitude+sign output.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit ABS_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  booth_seq_mult_if.slave  bus
);
  localparam int EW = WIDTH + 1;
  localparam int CW = clog2(WIDTH + 2);

  state_t             state, state_nxt;
  logic [EW-1:0]      a_r, q_r, m_r;
  logic               q1_r;
  logic [CW-1:0]      cnt;
  logic               sgn_r;
  logic [2*WIDTH-1:0] p_r;
  logic               neg_r;

  logic [EW-1:0]      a_s, q_s;
  logic               q1_s;
  logic [2*WIDTH-1:0] prod, prod_out;
  logic               prod_neg;
  logic               last_step;

  booth_step #(.W(EW)) u_step (
    .a       (a_r),
    .m       (m_r),
    .q       (q_r),
    .q_1     (q1_r),
    .a_nxt   (a_s),
    .q_nxt   (q_s),
    .q_1_nxt (q1_s)
  );

  // Operands are widened by one bit, so the low 2*WIDTH bits are exact in both modes.
  assign prod      = {a_s[WIDTH-2:0], q_s};
  assign prod_neg  = ABS_OUT && sgn_r && prod[2*WIDTH-1];
  assign prod_out  = prod_neg ? -prod : prod;
  assign last_step = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = CALC;
      CALC:    if (last_step)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      q_r   <= '0;
      m_r   <= '0;
      q1_r  <= 1'b0;
      cnt   <= '0;
      sgn_r <= 1'b0;
      p_r   <= '0;
      neg_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          a_r   <= '0;
          q_r   <= {bus.in_signed & bus.in_x[WIDTH-1], bus.in_x};
          m_r   <= {bus.in_signed & bus.in_y[WIDTH-1], bus.in_y};
          q1_r  <= 1'b0;
          cnt   <= CW'(WIDTH + 1);
          sgn_r <= bus.in_signed;
        end
        CALC: begin
          a_r  <= a_s;
          q_r  <= q_s;
          q1_r <= q1_s;
          cnt  <= cnt - CW'(1);
          if (last_step) begin
            p_r   <= prod_out;
            neg_r <= prod_neg;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == CALC);
  assign bus.out_p     = p_r;
  assign bus.out_neg   = neg_r;
endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed checks for booth_seq_mult: vector table at WIDTH=8, backpressure,
// async reset mid-operation, ABS_OUT=0, and an exhaustive WIDTH=4 sweep.
module tb_booth_seq_mult;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_seq_mult_if #(.WIDTH(8)) ba ();
  booth_seq_mult_if #(.WIDTH(8)) bz ();
  booth_seq_mult_if #(.WIDTH(4)) b4 ();

  booth_seq_mult #(.WIDTH(8), .ABS_OUT(1'b1)) u_a (.clk(clk), .rst(rst), .bus(ba.slave));
  booth_seq_mult #(.WIDTH(8), .ABS_OUT(1'b0)) u_z (.clk(clk), .rst(rst), .bus(bz.slave));
  booth_seq_mult #(.WIDTH(4), .ABS_OUT(1'b1)) u_4 (.clk(clk), .rst(rst), .bus(b4.slave));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          s;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] p;
    bit          neg;
  } vec_t;

  vec_t    tbl[13];
  logic [8:0] exp4_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat counts cycles from the handshake cycle to the first cycle with out_valid.
  // in_signed is flipped during CALC to show the mode was captured at load.
  task automatic op8(input bit s, input logic [7:0] x, input logic [7:0] y,
                     output logic [15:0] p, output logic neg, output int lat, output bit ok);
    int w;
    ba.in_signed = s; ba.in_x = x; ba.in_y = y; ba.in_valid = 1'b1;
    w = 0;
    while (!ba.in_ready && w < 40) begin tick(); w++; end
    tick();
    ba.in_valid = 1'b0; ba.in_signed = ~s; ba.in_x = 8'h5A; ba.in_y = 8'hA5;
    lat = 1;
    while (!ba.out_valid && lat < 40) begin tick(); lat++; end
    ok = ba.out_valid; p = ba.out_p; neg = ba.out_neg;
    ba.out_ready = 1'b1;
    tick();
    ba.out_ready = 1'b0;
  endtask

  function automatic logic [8:0] ref4(input bit s, input logic [3:0] x, input logic [3:0] y);
    int xi, yi, pr;
    logic neg;
    logic [7:0] p;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    pr = xi * yi;
    neg = s && (pr < 0);
    p = neg ? 8'(-pr) : 8'(pr);
    return {neg, p};
  endfunction

  initial begin
    logic [15:0] p;
    logic        neg;
    int          lat, w;
    bit          ok;

    tbl[0]  = '{1'b1, 8'hFD, 8'h05, 16'h000F, 1'b1};
    tbl[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
    tbl[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0};
    tbl[3]  = '{1'b1, 8'h80, 8'h80, 16'h4000, 1'b0};
    tbl[4]  = '{1'b1, 8'h80, 8'h7F, 16'h3F80, 1'b1};
    tbl[5]  = '{1'b0, 8'h07, 8'h06, 16'h002A, 1'b0};
    tbl[6]  = '{1'b1, 8'h00, 8'h85, 16'h0000, 1'b0};
    tbl[7]  = '{1'b1, 8'h85, 8'h00, 16'h0000, 1'b0};
    tbl[8]  = '{1'b0, 8'h80, 8'h80, 16'h4000, 1'b0};
    tbl[9]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 1'b0};
    tbl[10] = '{1'b0, 8'hFD, 8'h05, 16'h04F1, 1'b0};
    tbl[11] = '{1'b1, 8'h05, 8'hFD, 16'h000F, 1'b1};
    tbl[12] = '{1'b1, 8'h01, 8'h80, 16'h0080, 1'b1};

    rst = 1'b1;
    ba.in_valid = 0; ba.in_signed = 0; ba.in_x = 0; ba.in_y = 0; ba.out_ready = 0;
    bz.in_valid = 0; bz.in_signed = 0; bz.in_x = 0; bz.in_y = 0; bz.out_ready = 0;
    b4.in_valid = 0; b4.in_signed = 0; b4.in_x = 0; b4.in_y = 0; b4.out_ready = 0;
    repeat (2) tick();
    check("reset in_ready",  ba.in_ready, 1);
    check("reset out_valid", ba.out_valid, 0);
    check("reset busy",      ba.busy, 0);
    check("reset out_p",     ba.out_p, 0);
    check("reset out_neg",   ba.out_neg, 0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      op8(tbl[i].s, tbl[i].x, tbl[i].y, p, neg, lat, ok);
      check($sformatf("vec%0d out_valid", i), ok, 1);
      check($sformatf("vec%0d latency", i), lat, 10);
      check($sformatf("vec%0d out_p", i), p, tbl[i].p);
      check($sformatf("vec%0d out_neg", i), neg, tbl[i].neg);
      check($sformatf("vec%0d drop", i), ba.out_valid, 0);
    end

    // Backpressure: result held while out_ready is low; new operands are ignored.
    ba.in_signed = 0; ba.in_x = 8'd7; ba.in_y = 8'd6; ba.in_valid = 1'b1;
    tick();
    ba.in_valid = 1'b0;
    w = 0;
    while (!ba.out_valid && w < 40) begin tick(); w++; end
    ba.in_valid = 1'b1; ba.in_x = 8'd9; ba.in_y = 8'd9;
    for (int c = 0; c < 5; c++) begin
      check("bp out_valid", ba.out_valid, 1);
      check("bp out_p",     ba.out_p, 16'd42);
      check("bp in_ready",  ba.in_ready, 0);
      tick();
    end
    ba.in_valid = 1'b0;
    ba.out_ready = 1'b1;
    tick();
    ba.out_ready = 1'b0;
    check("bp released", ba.out_valid, 0);
    check("bp idle",     ba.in_ready, 1);
    tick(); tick();
    check("bp not queued busy",  ba.busy, 0);
    check("bp not queued valid", ba.out_valid, 0);

    // Async reset during the fourth CALC step.
    ba.in_signed = 1; ba.in_x = 8'hFD; ba.in_y = 8'h05; ba.in_valid = 1'b1;
    tick();
    ba.in_valid = 1'b0;
    tick(); tick(); tick();
    check("pre-rst busy", ba.busy, 1);
    rst = 1'b1;
    #1;
    check("rst in_ready",  ba.in_ready, 1);
    check("rst busy",      ba.busy, 0);
    check("rst out_valid", ba.out_valid, 0);
    check("rst out_p",     ba.out_p, 0);
    check("rst out_neg",   ba.out_neg, 0);
    #2 rst = 1'b0;
    tick();
    op8(1'b0, 8'd7, 8'd6, p, neg, lat, ok);
    check("post-rst valid", ok, 1);
    check("post-rst out_p", p, 16'd42);

    // Two's-complement output variant.
    bz.in_signed = 1; bz.in_x = 8'h80; bz.in_y = 8'h7F; bz.in_valid = 1'b1;
    tick();
    bz.in_valid = 1'b0;
    w = 0;
    while (!bz.out_valid && w < 40) begin tick(); w++; end
    check("abs0 out_valid", bz.out_valid, 1);
    check("abs0 out_p",     bz.out_p, 16'hC080);
    check("abs0 out_neg",   bz.out_neg, 0);
    bz.out_ready = 1'b1;
    tick();
    bz.out_ready = 1'b0;

    // WIDTH=4: every operand pair in both modes, back-to-back with out_ready held high.
    b4.out_ready = 1'b1;
    fork
      begin
        for (int m = 0; m < 2; m++)
          for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
              int wd;
              b4.in_signed = m[0]; b4.in_x = 4'(x); b4.in_y = 4'(y); b4.in_valid = 1'b1;
              wd = 0;
              while (!b4.in_ready && wd < 20) begin tick(); wd++; end
              exp4_q.push_back(ref4(m[0], 4'(x), 4'(y)));
              tick();
            end
        b4.in_valid = 1'b0;
      end
      begin
        int got, cyc;
        logic [8:0] e;
        got = 0; cyc = 0;
        while (got < 512 && cyc < 6000) begin
          tick();
          cyc++;
          if (b4.out_valid) begin
            e = exp4_q.pop_front();
            check($sformatf("w4 #%0d", got), {b4.out_neg, b4.out_p}, e);
            got++;
          end
        end
        check("w4 result count", got, 512);
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
